// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake: logic/arith ops, shifts, compare unit and an
// iterative shift-add multiplier that stalls the input side while it runs.
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       cmp_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept, is_sub, is_mul;
  logic [WIDTH-1:0] b_eff, sum, diff, alu_res, acc_next;
  logic             carry, cmp_carry, lt, ltu, eq, cmp_bit, alu_cout, alu_ovf;
  logic [SHW-1:0]   shamt;

  assign out_valid = (state_q == StHold);
  assign in_ready  = (state_q != StBusy) & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

  assign is_sub = (ALU_control == 4'b0110);
  assign is_mul = MUL_EN && (ALU_control == 4'b1000);
  assign b_eff  = is_sub ? ~src2 : src2;
  assign {carry, sum}     = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign {cmp_carry, diff} = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};

  // Sign-mismatch shortcut keeps signed compare correct when the subtraction overflows.
  assign lt    = (src1[WIDTH-1] ^ src2[WIDTH-1]) ? src1[WIDTH-1] : diff[WIDTH-1];
  assign ltu   = ~cmp_carry;
  assign eq    = (src1 == src2);
  assign shamt = src2[SHW-1:0];

  always_comb begin
    cmp_bit = 1'b0;
    unique case (cmp_mode)
      3'b000: cmp_bit = lt;
      3'b001: cmp_bit = ~lt;
      3'b010: cmp_bit = lt | eq;
      3'b011: cmp_bit = ~lt & ~eq;
      3'b100: cmp_bit = eq;
      3'b101: cmp_bit = ~eq;
      3'b110: cmp_bit = ltu;
      3'b111: cmp_bit = ~ltu;
      default: cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (ALU_control)
      4'b0000: alu_res = src1 & src2;
      4'b0001: alu_res = src1 | src2;
      4'b0010, 4'b0110: begin
        alu_res  = sum;
        alu_cout = carry;
        alu_ovf  = (src1[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
      4'b1100: alu_res = ~(src1 | src2);
      4'b1101: alu_res = ~(src1 & src2);
      4'b0011: alu_res = src1 << shamt;
      4'b0100: alu_res = src1 >> shamt;
      4'b0101: alu_res = $unsigned($signed(src1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (state_q == StBusy) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        result_d = acc_next;
        zero_d   = ~|acc_next;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
        state_d  = StHold;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (accept) begin
      if (is_mul) begin
        mcand_d  = src1;
        mplier_d = src2;
        acc_d    = '0;
        cnt_d    = SHW'(WIDTH - 1);
        state_d  = StBusy;
      end else begin
        result_d = alu_res;
        zero_d   = ~|alu_res;
        cout_d   = alu_cout;
        ovf_d    = alu_ovf;
        state_d  = StHold;
      end
    end else if (state_q == StHold && out_ready) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
